// File: rtl/uart_pkg.sv
// uart_pkg: shared FSM state encoding and a clog2 helper for the UART TX slice.
// No ports; imported by sync_fifo and uart_tx_fifo.
package uart_pkg;

  localparam int ST_W = 3;

  typedef enum logic [ST_W-1:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: DEPTH x DW synchronous FIFO with show-ahead read data.
// Ports: sysclk, cpu_resetn, wr_en/wr_data, rd_en/rd_data, full, empty, count.
module sync_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int DW    = 8
) (
  input  logic                   sysclk,
  input  logic                   cpu_resetn,
  input  logic                   wr_en,
  input  logic [DW-1:0]          wr_data,
  input  logic                   rd_en,
  output logic [DW-1:0]          rd_data,
  output logic                   full,
  output logic                   empty,
  output logic [clog2(DEPTH):0]  count
);

  localparam int AW = clog2(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW:0]   wptr_q, wptr_d;
  logic [AW:0]   rptr_q, rptr_d;
  logic          wr_ok, rd_ok;

  // Extra pointer MSB separates full from empty when indices match.
  assign full  = (wptr_q[AW] != rptr_q[AW]) &&
                 (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign empty = (wptr_q == rptr_q);
  assign count = wptr_q - rptr_q;

  assign rd_data = mem_q[rptr_q[AW-1:0]];

  assign wr_ok = wr_en & ~full;
  assign rd_ok = rd_en & ~empty;

  always_comb begin
    wptr_d = wptr_q + {{AW{1'b0}}, wr_ok};
    rptr_d = rptr_q + {{AW{1'b0}}, rd_ok};
  end

  always_ff @(posedge sysclk or negedge cpu_resetn) begin
    if (!cpu_resetn) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge sysclk) begin
    if (wr_ok) mem_q[wptr_q[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: FIFO-buffered LSB-first UART transmitter; UART_TX_PARITY_EN adds even parity.
// Ports: sysclk, cpu_resetn, wr_en, wr_data, full, count, busy, uart_tx (registered, idles high).
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DIV       = 868,
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 16,
  parameter int STOP_BITS = 1
) (
  input  logic                   sysclk,
  input  logic                   cpu_resetn,
  input  logic                   wr_en,
  input  logic [DATA_W-1:0]      wr_data,
  output logic                   full,
  output logic [clog2(DEPTH):0]  count,
  output logic                   busy,
  output logic                   uart_tx
);

  localparam int BW = clog2(DIV);
  localparam int IW = clog2(DATA_W);
  localparam logic [BW-1:0] BAUD_LAST = BW'(DIV - 1);
  localparam logic [IW-1:0] LAST_BIT  = IW'(DATA_W - 1);
  localparam logic [IW-1:0] STOP_LAST = IW'(STOP_BITS - 1);

  state_e            state_q, state_d;
  logic [BW-1:0]     baud_q, baud_d;
  logic [IW-1:0]     bit_q, bit_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              tx_q, tx_d;
  logic              pop, tick;
  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_data;
`ifdef UART_TX_PARITY_EN
  logic              par_q, par_d;
`endif

  sync_fifo #(
    .DEPTH (DEPTH),
    .DW    (DATA_W)
  ) u_fifo (
    .sysclk     (sysclk),
    .cpu_resetn (cpu_resetn),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .rd_en      (pop),
    .rd_data    (fifo_data),
    .full       (full),
    .empty      (fifo_empty),
    .count      (count)
  );

  assign tick    = (baud_q == BAUD_LAST);
  assign busy    = (state_q != IDLE) | (count != '0);
  assign uart_tx = tx_q;

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    pop     = 1'b0;
    if (state_q != IDLE) baud_d = tick ? '0 : baud_q + 1'b1;
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = START;
          baud_d  = '0;
        end
      end
      START: begin
        if (tick) begin
          state_d = DATA;
          bit_d   = '0;
        end
      end
      DATA: begin
        if (tick) begin
          shift_d = shift_q >> 1;
          if (bit_q == LAST_BIT) begin
            bit_d = '0;
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      PARITY: begin
        if (tick) state_d = STOP;
      end
      STOP: begin
        if (tick) begin
          if (bit_q == STOP_LAST) begin
            bit_d = '0;
            // Chain straight into the next start bit.
            if (!fifo_empty) begin
              pop     = 1'b1;
              state_d = START;
            end else begin
              state_d = IDLE;
            end
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (pop) shift_d = fifo_data;
  end

`ifdef UART_TX_PARITY_EN
  always_comb begin
    par_d = par_q;
    if (pop) par_d = ^fifo_data;
  end
`endif

  // Line level follows the registered state, one edge behind it.
  always_comb begin
    tx_d = 1'b1;
    unique case (state_q)
      START:  tx_d = 1'b0;
      DATA:   tx_d = shift_q[0];
`ifdef UART_TX_PARITY_EN
      PARITY: tx_d = par_q;
`endif
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge sysclk or negedge cpu_resetn) begin
    if (!cpu_resetn) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

`ifdef UART_TX_PARITY_EN
  always_ff @(posedge sysclk or negedge cpu_resetn) begin
    if (!cpu_resetn) par_q <= 1'b0;
    else             par_q <= par_d;
  end
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: randomized and directed bench for uart_tx_fifo.
// Instance A: DIV=4/8 bits/DEPTH=4/1 stop; instance B: DIV=3/5 bits/2 stops.
module tb_uart_tx_fifo;

  localparam int DIV_A   = 4;
  localparam int DW_A    = 8;
  localparam int DEPTH_A = 4;
  localparam int SB_A    = 1;
  localparam int DIV_B   = 3;
  localparam int DW_B    = 5;
  localparam int DEPTH_B = 4;
  localparam int SB_B    = 2;
`ifdef UART_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int FL_A = 1 + DW_A + PAR + SB_A;
  localparam int FL_B = 1 + DW_B + PAR + SB_B;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wr_en_a, wr_en_b;
  logic [7:0] wr_data_a;
  logic [4:0] wr_data_b;
  logic       full_a, full_b, busy_a, busy_b, tx_a, tx_b;
  logic [2:0] count_a, count_b;

  int checks = 0;
  int failures = 0;

  logic [7:0] mq[$];
  logic [7:0] m_cur;
  bit         m_act;
  int         m_pos;
  logic       m_line;

  always #5 clk = ~clk;

  uart_tx_fifo #(
    .DIV(DIV_A), .DATA_W(DW_A), .DEPTH(DEPTH_A), .STOP_BITS(SB_A)
  ) dut_a (
    .sysclk(clk), .cpu_resetn(rst_n), .wr_en(wr_en_a),
    .wr_data(wr_data_a), .full(full_a), .count(count_a),
    .busy(busy_a), .uart_tx(tx_a)
  );

  uart_tx_fifo #(
    .DIV(DIV_B), .DATA_W(DW_B), .DEPTH(DEPTH_B), .STOP_BITS(SB_B)
  ) dut_b (
    .sysclk(clk), .cpu_resetn(rst_n), .wr_en(wr_en_b),
    .wr_data(wr_data_b), .full(full_b), .count(count_b),
    .busy(busy_b), .uart_tx(tx_b)
  );

  // Level of frame bit idx for data d: start, LSB-first data, parity, stops.
  function automatic logic fbit(input logic [7:0] d, input int dw,
                                input int idx);
    logic x;
    if (idx == 0) return 1'b0;
    if (idx <= dw) return d[idx-1];
    if (PAR == 1 && idx == dw + 1) begin
      x = 1'b0;
      for (int i = 0; i < dw; i++) x ^= d[i];
      return x;
    end
    return 1'b1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_act  = 0;
    m_pos  = 0;
    m_line = 1'b1;
  endtask

  // One clock: drive A, advance the frame-level model, compare A.
  task automatic tick(input logic we, input logic [7:0] wd);
    logic nl;
    int   sz;
    bit   ending;
    wr_en_a   = we;
    wr_data_a = wd;
    @(posedge clk);
    if (rst_n) begin
      sz     = mq.size();
      nl     = m_act ? fbit(m_cur, DW_A, m_pos / DIV_A) : 1'b1;
      ending = m_act && (m_pos == FL_A * DIV_A - 1);
      if (m_act) m_pos++;
      if (ending) m_act = 0;
      if (!m_act && sz > 0) begin
        m_cur = mq.pop_front();
        m_act = 1;
        m_pos = 0;
      end
      if (we && sz < DEPTH_A) mq.push_back(wd);
      m_line = nl;
    end
    #1;
    chk("a_tx", 32'(tx_a), 32'(m_line));
    chk("a_count", 32'(count_a), mq.size());
    chk("a_full", 32'(full_a), 32'(mq.size() == DEPTH_A));
    chk("a_busy", 32'(busy_a), 32'(m_act || mq.size() > 0));
  endtask

  initial begin
    logic [7:0] bd;
    int         t, idx, f;
    rst_n     = 1'b0;
    wr_en_a   = 1'b0;
    wr_data_a = '0;
    wr_en_b   = 1'b0;
    wr_data_b = '0;
    model_reset();
    #12;
    chk("rst_tx_a", 32'(tx_a), 1);
    chk("rst_count_a", 32'(count_a), 0);
    chk("rst_full_a", 32'(full_a), 0);
    chk("rst_busy_a", 32'(busy_a), 0);
    chk("rst_tx_b", 32'(tx_b), 1);
    chk("rst_busy_b", 32'(busy_b), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) tick(1'b0, 8'h00);

    // Single byte, then parity-sensitive pair, then overfill by one.
    tick(1'b1, 8'h55);
    repeat (45) tick(1'b0, 8'h00);
    tick(1'b1, 8'h07);
    tick(1'b1, 8'h03);
    repeat (100) tick(1'b0, 8'h00);
    for (int i = 1; i <= 6; i++) tick(1'b1, 8'(i));
    repeat (5 * FL_A * DIV_A + 20) tick(1'b0, 8'h00);

    // Instance B: 0x1F then 0x00, contiguous 5-bit/2-stop frames.
    for (int k = 0; k < 64; k++) begin
      wr_en_b   = (k < 2);
      wr_data_b = (k == 0) ? 5'h1F : 5'h00;
      tick(1'b0, 8'h00);
      wr_en_b = 1'b0;
      if (k < 2) begin
        chk("b_tx_pre", 32'(tx_b), 1);
      end else begin
        t   = k - 2;
        idx = t / DIV_B;
        f   = idx / FL_B;
        bd  = (f == 0) ? 8'h1F : 8'h00;
        chk("b_tx", 32'(tx_b),
            (f < 2) ? 32'(fbit(bd, DW_B, idx % FL_B)) : 32'd1);
      end
      chk("b_busy", 32'(busy_b), 32'(k < 1 + 2 * FL_B * DIV_B));
    end

    // Random traffic.
    for (int i = 0; i < 800; i++)
      tick($urandom_range(0, 9) < 3, 8'($urandom));
    repeat (DEPTH_A * FL_A * DIV_A + 60) tick(1'b0, 8'h00);

    // Reset mid-frame with three entries queued.
    for (int i = 0; i < 4; i++) tick(1'b1, 8'($urandom));
    repeat (6) tick(1'b0, 8'h00);
    chk("pre_rst_count", 32'(count_a), 3);
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_async_tx", 32'(tx_a), 1);
    chk("rst_async_count", 32'(count_a), 0);
    chk("rst_async_busy", 32'(busy_a), 0);
    repeat (3) tick(1'b0, 8'h00);
    #3;
    rst_n = 1'b1;
    repeat (100) tick(1'b0, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
